branch_resolve_unit: RTL and testbench

Parametrised successor to the combinational branch-condition decoder. It resolves conditional branches and jumps from the ALU flags in EX and compares each outcome against the fetch-time prediction. It owns a BHT of 2-bit saturating counters that feeds predictions to IF. Mispredicts produce a registered one-cycle flush plus a redirect PC to the PC-select mux.

---
 rtl/branch_resolve_unit_pkg.sv | 46 ++++
 rtl/branch_resolve_unit_bht_2bit.sv | 31 +++
 rtl/branch_resolve_unit.sv | 119 +++++++++++
 tb/tb_branch_resolve_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants and helpers for the branch resolve unit: branch funct3
// encodings, BHT counter states, the saturating update and the condition decoder.
package branch_resolve_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != BHT_ST) nxt = ctr + 2'b01;
      else               nxt = ctr;
    end else begin
      if (ctr != BHT_SNT) nxt = ctr - 2'b01;
      else                nxt = ctr;
    end
    return nxt;
  endfunction

  // cf = 1 means the subtraction rs1 - rs2 produced no borrow.
  function automatic logic cond_taken(input logic [2:0] func3, input logic cf,
                                      input logic zf, input logic vf, input logic sf);
    logic t;
    case (func3)
      BR_BEQ:  t = zf;
      BR_BNE:  t = ~zf;
      BR_BLT:  t = (sf != vf);
      BR_BGE:  t = (sf == vf);
      BR_BLTU: t = ~cf;
      BR_BGEU: t = cf;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Branch history table of 2-bit saturating counters: one asynchronous read port,
// one saturating update port, all counters reset to weakly not-taken.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  localparam int IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [BHT_DEPTH];

  // Counter array; the read port sees the pre-update value within the cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= BHT_WNT;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= bht_next(ctr_q[upd_idx], upd_taken);
    end
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves EX branches/jumps, checks the fetch prediction,
// raises a registered flush/redirect and trains the BHT. Optional macro:
// BRU_PERF_CNT_EN adds branch and mispredict performance counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PERF_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_pred_taken,
  input  logic            rs_valid,
  input  logic            rs_is_jump,
  input  logic [2:0]      rs_func3,
  input  logic            rs_cf,
  input  logic            rs_zf,
  input  logic            rs_vf,
  input  logic            rs_sf,
  input  logic [XLEN-1:0] rs_pc,
  input  logic [XLEN-1:0] rs_target,
  input  logic            rs_pred_taken,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            resolved_taken
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
`endif
);

  localparam int BHT_IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]      lk_ctr_s;
  logic            taken_s;
  logic            accept_s;
  logic            mispredict_s;
  logic            upd_en_s;
  logic            flush_q, flush_d;
  logic            shadow_q, shadow_d;
  logic            resolved_q, resolved_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic            unused_s;

  bht_2bit #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (lk_pc[BHT_IDX_W+1:2]),
    .rd_ctr    (lk_ctr_s),
    .upd_en    (upd_en_s),
    .upd_idx   (rs_pc[BHT_IDX_W+1:2]),
    .upd_taken (taken_s)
  );

  assign lk_pred_taken = lk_ctr_s[1];
  assign unused_s      = ^{lk_pc[XLEN-1:BHT_IDX_W+2], lk_pc[1:0], lk_ctr_s[0]};

  // Resolve outcome; the instruction in EX during the flush cycle is wrong-path.
  always_comb begin
    taken_s      = rs_is_jump ? 1'b1 : cond_taken(rs_func3, rs_cf, rs_zf, rs_vf, rs_sf);
    accept_s     = rs_valid & ~shadow_q;
    mispredict_s = accept_s & (taken_s != rs_pred_taken);
    upd_en_s     = accept_s & ~rs_is_jump;
    flush_d      = mispredict_s;
    shadow_d     = mispredict_s;
    redirect_d   = redirect_q;
    resolved_d   = resolved_q;
    if (accept_s) begin
      redirect_d = taken_s ? rs_target : (rs_pc + XLEN'(32'd4));
      resolved_d = taken_s;
    end else begin
      redirect_d = redirect_q;
      resolved_d = resolved_q;
    end
  end

  // Output and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      shadow_q   <= 1'b0;
      resolved_q <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q    <= flush_d;
      shadow_q   <= shadow_d;
      resolved_q <= resolved_d;
      redirect_q <= redirect_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign resolved_taken = resolved_q;

`ifdef BRU_PERF_CNT_EN
  logic [PERF_W-1:0] perf_br_q, perf_mp_q;

  // Wrapping event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (accept_s)     perf_br_q <= perf_br_q + PERF_W'(32'd1);
      if (mispredict_s) perf_mp_q <= perf_mp_q + PERF_W'(32'd1);
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`else
  localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit: flags come from real
// operand subtraction, expectations from operand comparisons and a counter model.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] lk_pc;
  logic            lk_pred_taken;
  logic            rs_valid, rs_is_jump;
  logic [2:0]      rs_func3;
  logic            rs_cf, rs_zf, rs_vf, rs_sf;
  logic [XLEN-1:0] rs_pc, rs_target;
  logic            rs_pred_taken;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            resolved_taken;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]     perf_branches, perf_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_pred_taken(lk_pred_taken),
    .rs_valid(rs_valid), .rs_is_jump(rs_is_jump), .rs_func3(rs_func3),
    .rs_cf(rs_cf), .rs_zf(rs_zf), .rs_vf(rs_vf), .rs_sf(rs_sf),
    .rs_pc(rs_pc), .rs_target(rs_target), .rs_pred_taken(rs_pred_taken),
    .flush(flush), .redirect_pc(redirect_pc), .resolved_taken(resolved_taken)
`ifdef BRU_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  typedef struct {
    bit          flush;
    bit          chk_redir;
    logic [31:0] redir;
    bit          chk_taken;
    bit          taken;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ctr_m[DEPTH];
  bit   shadow_m;
  int   perf_b_m, perf_m_m;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) ctr_m[i] = 1;
    shadow_m = 1'b0;
    perf_b_m = 0;
    perf_m_m = 0;
  endfunction

  // One EX cycle: called just after a negedge, returns at the next negedge.
  task automatic step(input bit v, input bit j, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input bit pred, input logic [31:0] lkpc, input string nm);
    logic [31:0] diff;
    logic [31:0] lk_v;
    bit   cond, taken, acc, mis;
    int   idx, lidx;
    exp_t e;
    diff = a - b;
    case (f3)
      3'b000:  cond = (a == b);
      3'b001:  cond = (a != b);
      3'b100:  cond = ($signed(a) < $signed(b));
      3'b101:  cond = ($signed(a) >= $signed(b));
      3'b110:  cond = (a < b);
      3'b111:  cond = (a >= b);
      default: cond = 1'b0;
    endcase
    taken = j ? 1'b1 : cond;
    rs_valid = v; rs_is_jump = j; rs_func3 = f3;
    rs_zf = (a == b);
    rs_cf = (a >= b);
    rs_sf = diff[31];
    rs_vf = (a[31] != b[31]) && (diff[31] != a[31]);
    rs_pc = pc; rs_target = tgt; rs_pred_taken = pred; lk_pc = lkpc;
    #1;
    lk_v = lkpc;
    lidx = int'(lk_v[7:2]);
    check($sformatf("lookup_%s_pc%h", nm, lkpc), {31'd0, lk_pred_taken}, {31'd0, (ctr_m[lidx] >= 2)});
    acc = v && !shadow_m;
    mis = acc && (taken != pred);
    e.flush = mis; e.chk_redir = mis;
    e.redir = taken ? tgt : pc + 32'd4;
    e.chk_taken = acc; e.taken = taken; e.name = nm;
    sb.push_back(e);
    if (acc && !j) begin
      idx = int'(pc[7:2]);
      if (taken) ctr_m[idx] = (ctr_m[idx] == 3) ? 3 : ctr_m[idx] + 1;
      else       ctr_m[idx] = (ctr_m[idx] == 0) ? 0 : ctr_m[idx] - 1;
    end
    if (acc) perf_b_m++;
    if (mis) perf_m_m++;
    shadow_m = mis;
    @(negedge clk);
  endtask

  // Monitor: after every active edge, retire one expectation against the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({"flush_", e.name}, {31'd0, flush}, {31'd0, e.flush});
        if (e.chk_redir) check({"redirect_", e.name}, redirect_pc, e.redir);
        if (e.chk_taken) check({"resolved_", e.name}, {31'd0, resolved_taken}, {31'd0, e.taken});
      end
    end
  end

  task automatic check_all_lookups(input string nm);
    logic [31:0] p;
    for (int i = 0; i < DEPTH; i++) begin
      p = 32'(i) << 2;
      lk_pc = p;
      #1;
      check($sformatf("%s_lookup_%h", nm, p), {31'd0, lk_pred_taken}, 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b, pc, tgt, lk;
    rst_n = 1'b0; lk_pc = '0; rs_valid = 1'b0; rs_is_jump = 1'b0; rs_func3 = 3'b000;
    rs_cf = 1'b0; rs_zf = 1'b0; rs_vf = 1'b0; rs_sf = 1'b0;
    rs_pc = '0; rs_target = '0; rs_pred_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_flush", {31'd0, flush}, 32'd0);
    check("reset_redirect", redirect_pc, 32'd0);
    check("reset_resolved", {31'd0, resolved_taken}, 32'd0);
    check_all_lookups("reset");

    step(1, 0, 3'b000, 32'd5, 32'd5, 32'h40, 32'h80, 0, 32'h40, "beq_mis");
    step(0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'h40, "beq_after");
    for (int k = 0; k < 3; k++)
      step(1, 0, 3'b110, 32'd9, 32'd3, 32'h10, 32'h200, 0, 32'h10, "bltu_nt");
    step(1, 0, 3'b110, 32'd3, 32'd9, 32'h10, 32'h200, 1, 32'h10, "bltu_t");
    step(0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'h10, "bltu_sat");
    step(1, 1, 3'b000, 32'd1, 32'd2, 32'h20, 32'h100, 0, 32'h20, "jalr_mis");
    step(1, 0, 3'b000, 32'd7, 32'd7, 32'h20, 32'h300, 0, 32'h20, "shadow_beq");
    step(0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'h20, "shadow_after");
    step(1, 0, 3'b001, 32'd4, 32'd4, 32'hFFFF_FFFC, 32'h400, 1, 32'hFFFF_FFFC, "bne_wrap");
    step(0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, "bne_after");

    for (int n = 0; n < 500; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      pc  = (32'($urandom_range(0, 63)) << 2) | (($urandom_range(0, 1) == 1) ? 32'hF000_0000 : 32'h0);
      tgt = $urandom & 32'hFFFF_FFFC;
      lk  = ($urandom_range(0, 1) == 1) ? pc : (32'($urandom_range(0, 63)) << 2);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
           a, b, pc, tgt, $urandom_range(0, 1) == 1, lk, $sformatf("rnd%0d", n));
    end

`ifdef BRU_PERF_CNT_EN
    check("perf_branches", perf_branches, 32'(perf_b_m));
    check("perf_mispredicts", perf_mispredicts, 32'(perf_m_m));
`endif

    // Async reset pulse in the middle of a cycle carrying a mispredict.
    begin
      exp_t e;
      rs_valid = 1'b1; rs_is_jump = 1'b1; rs_pc = 32'h40; rs_target = 32'h80;
      rs_pred_taken = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      rs_valid = 1'b0;
      model_reset();
      e.flush = 1'b0; e.chk_redir = 1'b1; e.redir = 32'h0;
      e.chk_taken = 1'b1; e.taken = 1'b0; e.name = "midrst";
      sb.push_back(e);
      @(negedge clk);
      rst_n = 1'b1;
    end
    check_all_lookups("midrst");
`ifdef BRU_PERF_CNT_EN
    check("perf_branches_rst", perf_branches, 32'd0);
    check("perf_mispredicts_rst", perf_mispredicts, 32'd0);
`endif

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
